tb_tcdm_traffic_gen: RTL

Testbench TCDM master that sits directly upstream of the bench's dummy TCDM memory slave and drives one of its ports. On `start_i` it writes `num_words_i` words of a deterministic pattern to consecutive word addresses, then reads them back and compares each response against the expected value. It reports a mismatch count, the first failing address and a response timeout. It is used to qualify memory models and stall injection before an accelerator is attached.

---
 rtl/tb_tcdm_gen_pkg.sv | 20 ++
 rtl/tb_tcdm_exp_fifo.sv | 55 +++++
 rtl/tb_tcdm_traffic_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tb_tcdm_gen_pkg.sv
// tb_tcdm_gen_pkg: shared types, defaults and data pattern for the TCDM traffic generator.
package tb_tcdm_gen_pkg;

    localparam int DEF_MAX_OUTSTANDING = 2;
    localparam int DEF_TIMEOUT         = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN_W,
        S_READ,
        S_DRAIN_R,
        S_DONE
    } tgen_state_e;

    function automatic logic [31:0] tgen_pattern(input logic [31:0] seed, input logic [15:0] k);
        return seed ^ {k, ~k};
    endfunction

endpackage

// File: rtl/tb_tcdm_exp_fifo.sv
// tb_tcdm_exp_fifo: expected {address, data} FIFO for in-flight reads; push and pop may coincide when full.
module tb_tcdm_exp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == CW'(DEPTH));
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push)
                r_wptr <= ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/tb_tcdm_traffic_gen.sv
// tb_tcdm_traffic_gen: TCDM master that writes a seeded pattern, reads it back and checks every response.
module tb_tcdm_traffic_gen
    import tb_tcdm_gen_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TIMEOUT         = DEF_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] num_words_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] first_err_addr_o,
    output logic        timeout_o,
    output logic        tcdm_req_o,
    output logic [31:0] tcdm_add_o,
    output logic        tcdm_wen_o,
    output logic [3:0]  tcdm_be_o,
    output logic [31:0] tcdm_data_o,
    input  logic        tcdm_gnt_i,
    input  logic [31:0] tcdm_r_data_i,
    input  logic        tcdm_r_valid_i
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    tgen_state_e r_state;
    logic [31:0] r_base;
    logic [15:0] r_num;
    logic [31:0] r_seed;
    logic [15:0] r_idx;
    logic        r_req;
    logic [31:0] r_add;
    logic        r_wen;
    logic [3:0]  r_be;
    logic [31:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic [OW-1:0] r_out;
    logic [TW-1:0] r_tmo;
    logic [15:0] r_err_cnt;
    logic [31:0] r_first;
    logic        r_err_seen;
    logic        r_timeout;

    logic          w_start;
    logic          w_grant;
    logic          w_rv_ok;
    logic          w_proto;
    logic [OW-1:0] w_out_nxt;
    logic          w_room;
    logic          w_tmo;
    logic          w_last;
    logic [15:0]   w_idx_nxt;
    logic          w_rd_phase;
    logic          w_pop;
    logic          w_mis;
    logic          w_empty;
    logic          w_full;
    logic [63:0]   w_exp;

    assign w_start    = (r_state == S_IDLE) & start_i;
    assign w_grant    = r_req & tcdm_gnt_i;
    assign w_rv_ok    = tcdm_r_valid_i & (r_out != '0);
    assign w_proto    = tcdm_r_valid_i & (r_out == '0);
    assign w_out_nxt  = r_out + OW'(w_grant) - OW'(w_rv_ok);
    // Room is judged on next cycle's count, so a newly raised req never exceeds the limit.
    assign w_room     = w_out_nxt < OW'(MAX_OUTSTANDING);
    assign w_tmo      = (r_tmo == TW'(TIMEOUT));
    assign w_last     = (r_idx == r_num - 16'd1);
    assign w_idx_nxt  = r_idx + 16'd1;
    assign w_rd_phase = (r_state == S_READ) | (r_state == S_DRAIN_R);
    assign w_pop      = w_rv_ok & w_rd_phase & ~w_empty;
    assign w_mis      = w_pop & (tcdm_r_data_i != w_exp[31:0]);

    tb_tcdm_exp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (64)
    ) u_exp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_tmo),
        .push_i  (w_grant & (r_state == S_READ)),
        .data_i  ({r_add, r_data}),
        .pop_i   (w_pop),
        .data_o  (w_exp),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_num   <= '0;
            r_seed  <= '0;
            r_idx   <= '0;
            r_req   <= 1'b0;
            r_add   <= '0;
            r_wen   <= 1'b1;
            r_be    <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tmo) begin
                r_state <= S_DONE;
                r_req   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start_i) begin
                        r_state <= S_WRITE;
                        r_busy  <= 1'b1;
                        r_base  <= base_addr_i;
                        r_num   <= num_words_i;
                        r_seed  <= seed_i;
                        r_idx   <= '0;
                        r_req   <= (num_words_i != '0);
                        r_add   <= base_addr_i;
                        r_wen   <= 1'b0;
                        r_be    <= 4'hF;
                        r_data  <= tgen_pattern(seed_i, 16'd0);
                    end
                    S_WRITE, S_READ: begin
                        if (r_num == '0) begin
                            r_state <= (r_state == S_WRITE) ? S_READ : S_DONE;
                        end else if (w_grant) begin
                            if (w_last) begin
                                r_req   <= 1'b0;
                                r_state <= (r_state == S_WRITE) ? S_DRAIN_W : S_DRAIN_R;
                            end else begin
                                r_req  <= w_room;
                                r_idx  <= w_idx_nxt;
                                r_add  <= r_base + {14'd0, w_idx_nxt, 2'b00};
                                r_data <= tgen_pattern(r_seed, w_idx_nxt);
                            end
                        end else if (!r_req) begin
                            r_req <= w_room;
                        end
                    end
                    S_DRAIN_W: if (w_out_nxt == '0) begin
                        r_state <= S_READ;
                        r_idx   <= '0;
                        r_req   <= 1'b1;
                        r_add   <= r_base;
                        r_wen   <= 1'b1;
                        r_data  <= tgen_pattern(r_seed, 16'd0);
                    end
                    S_DRAIN_R: if (w_out_nxt == '0)
                        r_state <= S_DONE;
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out      <= '0;
            r_tmo      <= '0;
            r_err_cnt  <= '0;
            r_first    <= '0;
            r_err_seen <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_out <= w_tmo ? '0 : w_out_nxt;
            r_tmo <= (w_tmo || tcdm_r_valid_i || r_out == '0) ? '0 : r_tmo + TW'(1);
            if (w_start) begin
                r_err_cnt  <= '0;
                r_first    <= '0;
                r_err_seen <= 1'b0;
                r_timeout  <= 1'b0;
            end else begin
                if ((w_mis || w_proto) && r_err_cnt != 16'hFFFF)
                    r_err_cnt <= r_err_cnt + 16'd1;
                if (w_mis && !r_err_seen) begin
                    r_first    <= w_exp[63:32];
                    r_err_seen <= 1'b1;
                end
                if (w_tmo)
                    r_timeout <= 1'b1;
            end
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign err_cnt_o        = r_err_cnt;
    assign first_err_addr_o = r_first;
    assign timeout_o        = r_timeout;
    assign tcdm_req_o       = r_req;
    assign tcdm_add_o       = r_add;
    assign tcdm_wen_o       = r_wen;
    assign tcdm_be_o        = r_be;
    assign tcdm_data_o      = r_data;

endmodule
